// File: rtl/baud_autocal.sv
// Auto-baud calibration: times a 0x55 sync character on rx and sets dvsr for a 16x baud tick.
// Ports: clk, reset (async, active-low), rx, start, abort -> dvsr, busy, locked, err. Option: BAUD_AUTOCAL_GLITCH_FILTER_EN.
module baud_autocal #(
  parameter int DVSR_W       = 11,
  parameter int CNT_W        = 20,
  parameter int OVS_LOG2     = 4,
  parameter int DEFAULT_DVSR = 650
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              start,
  input  logic              abort,
  output logic [DVSR_W-1:0] dvsr,
  output logic              busy,
  output logic              locked,
  output logic              err
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_START = 2'd1;
  localparam logic [1:0] MEASURE    = 2'd2;
  localparam logic [1:0] CALC       = 2'd3;

  localparam int S = 3 + OVS_LOG2;

  localparam logic [CNT_W:0]    ONE   = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]    TWO   = (CNT_W+1)'(2);
  localparam logic [CNT_W:0]    HALF  = ONE << (S-1);
  localparam logic [CNT_W:0]    QMAX  = (CNT_W+1)'(2**DVSR_W);
  localparam logic [CNT_W-1:0]  CMAX  = '1;
  localparam logic [CNT_W-1:0]  CONE  = CNT_W'(1);
  localparam logic [DVSR_W-1:0] DVSR0 = DVSR_W'(DEFAULT_DVSR);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] meas;
  logic [1:0]       ecnt;
  logic [CNT_W:0]   q;

  logic s1;
  logic s2;
  logic line;
  logic prev;
  logic fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
    end
  end

`ifdef BAUD_AUTOCAL_GLITCH_FILTER_EN
  logic f1;
  logic f2;
  logic filt;

  // 3-sample majority: a single low sample can never win the vote
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f1   <= 1'b1;
      f2   <= 1'b1;
      filt <= 1'b1;
    end else begin
      f1   <= s2;
      f2   <= f1;
      filt <= (s2 & f1) | (s2 & f2) | (f1 & f2);
    end
  end

  assign line = filt;
`else
  assign line = s2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b1;
    else        prev <= line;
  end

  assign fall = prev & ~line;

  // cycles per oversample tick, rounded to nearest
  assign q = ({1'b0, meas} + HALF) >> S;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      meas   <= '0;
      ecnt   <= '0;
      dvsr   <= DVSR0;
      busy   <= 1'b0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else if (abort && state != IDLE) begin
      state  <= IDLE;
      busy   <= 1'b0;
      err    <= 1'b0;
      locked <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= WAIT_START;
            busy   <= 1'b1;
            err    <= 1'b0;
            locked <= 1'b0;
          end
        end
        WAIT_START: begin
          if (fall) begin
            cnt   <= '0;
            ecnt  <= '0;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (cnt == CMAX) begin
            err    <= 1'b1;
            locked <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CONE;
            if (fall) begin
              // cnt lags the start edge by one cycle; +1 gives the true distance
              if (ecnt == 2'd3) begin
                meas  <= cnt + CONE;
                state <= CALC;
              end else begin
                ecnt <= ecnt + 2'd1;
              end
            end
          end
        end
        CALC: begin
          if (q < TWO || q > QMAX) begin
            err <= 1'b1;
          end else begin
            dvsr   <= DVSR_W'(q - ONE);
            locked <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_baud_autocal.sv
// Directed bench for baud_autocal: nominal, too-fast, abort, reset, timeout and glitch cases.
// Second instance uses CNT_W=12 so the timeout path is reachable quickly.
module tb_baud_autocal;

  logic        clk;
  logic        reset;
  logic        rx;
  logic        start;
  logic        abort;
  logic [10:0] dvsr;
  logic        busy;
  logic        locked;
  logic        err;

  logic        start2;
  logic        abort2;
  logic [10:0] dvsr2;
  logic        busy2;
  logic        locked2;
  logic        err2;

  int total;
  int bad;
  int cyc;
  int lat;

`ifdef BAUD_AUTOCAL_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  baud_autocal u_dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .start  (start),
    .abort  (abort),
    .dvsr   (dvsr),
    .busy   (busy),
    .locked (locked),
    .err    (err)
  );

  baud_autocal #(.CNT_W(12)) u_to (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .start  (start2),
    .abort  (abort2),
    .dvsr   (dvsr2),
    .busy   (busy2),
    .locked (locked2),
    .err    (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // drive one 0x55 frame, LSB first; optionally pulse start mid-measurement
  task automatic frame(input int bpc, input bit poke, output int l);
    logic [9:0] bits;
    int edge_c;
    int done_c;
    logic bprev;
    bits   = {1'b1, 8'h55, 1'b0};
    edge_c = -1;
    done_c = -1;
    bprev  = busy;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < bpc; c++) begin
        @(posedge clk);
        #1;
        if (bprev && !busy && done_c < 0) done_c = cyc;
        bprev = busy;
        if (c == 0 && !bits[i] && rx) edge_c = cyc;
        rx    = bits[i];
        start = poke && i == 4 && c == 0;
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bprev && !busy && done_c < 0) done_c = cyc;
      bprev = busy;
      start = 1'b0;
    end
    l = done_c - edge_c;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    rx     = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;

    step(3);
    check("rst_dvsr", dvsr, 650);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    step(3);

    // nominal 115200 at 100 MHz, with an ignored start mid-measure
    pulse_start;
    check("nom_busy_on", busy, 1);
    frame(868, 1'b1, lat);
    check("nom_dvsr", dvsr, 53);
    check("nom_locked", locked, 1);
    check("nom_err", err, 0);
    check("nom_busy", busy, 0);
    check("nom_latency", lat, LAT);

    // too fast: 8 cycles/bit, q=1
    pulse_start;
    check("fast_busy_on", busy, 1);
    check("fast_locked_clr", locked, 0);
    frame(8, 1'b0, lat);
    check("fast_err", err, 1);
    check("fast_locked", locked, 0);
    check("fast_dvsr", dvsr, 53);
    check("fast_busy", busy, 0);

    // abort during measurement
    pulse_start;
    check("abt_err_clr", err, 0);
    rx = 1'b0;
    step(30);
    rx = 1'b1;
    step(10);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abt_busy", busy, 0);
    check("abt_err", err, 0);
    check("abt_locked", locked, 0);
    check("abt_dvsr", dvsr, 53);

    // asynchronous reset mid-measurement
    pulse_start;
    rx = 1'b0;
    step(30);
    rx = 1'b1;
    step(30);
    rx = 1'b0;
    step(5);
    #3;
    reset = 1'b0;
    #1;
    check("mrst_dvsr", dvsr, 650);
    check("mrst_busy", busy, 0);
    check("mrst_locked", locked, 0);
    check("mrst_err", err, 0);
    step(2);
    reset = 1'b1;
    rx    = 1'b1;
    step(5);
    check("mrst_idle", busy, 0);

    // timeout: one edge then rx held low
    step(1);
    start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    check("to_busy_on", busy2, 1);
    rx = 1'b0;
    for (int k = 0; k < 6000 && busy2; k++) step(1);
    check("to_busy", busy2, 0);
    check("to_err", err2, 1);
    check("to_dvsr", dvsr2, 650);
    check("to_locked", locked2, 0);
    rx = 1'b1;
    step(10);

    // single-cycle low glitch while waiting for the start edge
    step(1);
    start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    check("gl_err_clr", err2, 0);
    step(5);
    rx = 1'b0;
    step(1);
    rx = 1'b1;
    step(4300);
`ifdef BAUD_AUTOCAL_GLITCH_FILTER_EN
    check("gl_busy", busy2, 1);
    check("gl_err", err2, 0);
    abort2 = 1'b1;
    step(1);
    abort2 = 1'b0;
    check("gl_abort", busy2, 0);
`else
    check("gl_busy", busy2, 0);
    check("gl_err", err2, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
